// File: rtl/regread_port.sv
// Single-entry register-read stage: captures two source operands and a tag, holds them under backpressure.
// Optional macro REGREAD_BYPASS_EN forwards same-cycle write-back data (G/R_in) into captured and held operands.
module regread_port #(
  parameter int unsigned TAGW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1023:0]     rf_q,
  input  logic [31:0]       G,
  input  logic [31:0]       R_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [TAGW-1:0]   req_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2,
  output logic [TAGW-1:0]   out_tag,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned DW       = 32;
  localparam int unsigned IW       = 5;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic [IW-1:0] h1;
  logic [IW-1:0] h2;
  logic          accept_c;
  logic          consume_c;
  logic          stalled_c;
  logic [DW-1:0] op1_c;
  logic [DW-1:0] op2_c;

  // r0 is hardwired to zero; other indices select their 32-bit slice of rf_q
  function automatic logic [DW-1:0] rf_word(input logic [1023:0] q, input logic [IW-1:0] idx);
    logic [DW-1:0] w;
    w = '0;
    if (idx != '0) w = q[{idx, 5'd0} +: DW];
    return w;
  endfunction

  assign req_ready = !out_valid || out_ready;
  assign accept_c  = req_valid && req_ready;
  assign consume_c = out_valid && out_ready;
  assign stalled_c = out_valid && !out_ready;

`ifdef REGREAD_BYPASS_EN
  logic          fwd1_c;
  logic          fwd2_c;
  logic          upd1_c;
  logic          upd2_c;

  // A register being written this cycle supplies G instead of its stale rf_q value
  assign fwd1_c = (rs1 != '0) && R_in[rs1];
  assign fwd2_c = (rs2 != '0) && R_in[rs2];
  assign op1_c  = fwd1_c ? G : rf_word(rf_q, rs1);
  assign op2_c  = fwd2_c ? G : rf_word(rf_q, rs2);
  assign upd1_c = stalled_c && (h1 != '0) && R_in[h1];
  assign upd2_c = stalled_c && (h2 != '0) && R_in[h2];
`else
  logic          unused_bypass;

  assign op1_c         = rf_word(rf_q, rs1);
  assign op2_c         = rf_word(rf_q, rs2);
  assign unused_bypass = ^{G, R_in, h1, h2};
`endif

  // Output entry: a new accept replaces it (no bubble), a lone consume empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      rd1       <= '0;
      rd2       <= '0;
      out_tag   <= '0;
      h1        <= '0;
      h2        <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      rd1       <= op1_c;
      rd2       <= op2_c;
      out_tag   <= req_tag;
      h1        <= rs1;
      h2        <= rs2;
    end else if (consume_c) begin
      out_valid <= 1'b0;
    end else begin
`ifdef REGREAD_BYPASS_EN
      if (upd1_c) rd1 <= G;
      if (upd2_c) rd2 <= G;
`endif
    end
  end

  // Backpressure cycle counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalled_c && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/regread_port.md
REGREAD_PORT -- requirements
Module: regread_port

Interface
REQ-001 The block SHALL have parameter TAGW, default 4, meaning width of the request tag carried through to the output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port rf_q, input, 1024 bits: register array contents, rN at bits [32N+31:32N].
REQ-005 The block SHALL have port G, input, 32 bits: write-back data bus driven into the register array this cycle.
REQ-006 The block SHALL have port R_in, input, 32 bits: one-hot register write enables, same cycle as G.
REQ-007 The block SHALL have port req_valid, input, 1 bit: read request valid.
REQ-008 The block SHALL have port req_ready, output, 1 bit: request accepted when req_valid && req_ready.
REQ-009 The block SHALL have ports rs1 and rs2, input, 5 bits each: source register indices.
REQ-010 The block SHALL have port req_tag, input, TAGW bits: opaque request tag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: operand pair valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid && out_ready.
REQ-013 The block SHALL have ports rd1 and rd2, output, 32 bits each: operand data for rs1 and rs2.
REQ-014 The block SHALL have port out_tag, output, TAGW bits: tag of the held request.
REQ-015 The block SHALL have port stall_cnt, output, 16 bits: cycles with out_valid && !out_ready, saturating at 16'hFFFF.

Function
REQ-016 The block SHALL hold one output entry: registers rd1, rd2, out_tag, the held indices h1/h2, and out_valid.
REQ-017 req_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-018 On accept, the block SHALL load rd1/rd2 from rf_q[rs1]/rf_q[rs2], load out_tag, h1 and h2, and set out_valid the next cycle (latency 1).
REQ-019 Index 0 SHALL always read 32'h0, regardless of rf_q, R_in[0] or G.
REQ-020 The block SHALL clear out_valid after a consumer accept when no new request is accepted in the same cycle.
REQ-021 When a consumer accept and a request accept occur in the same cycle, the block SHALL replace the entry, keep out_valid=1, and produce no bubble.
REQ-022 The block SHALL hold rd1, rd2 and out_tag stable while out_valid && !out_ready, except as stated in REQ-028.
REQ-023 The block SHALL increment stall_cnt by 1 each cycle with out_valid && !out_ready, and SHALL NOT wrap it.
REQ-024 The block SHALL treat a non-one-hot R_in value as undefined input; the bench SHALL NOT drive it.

Reset
REQ-025 While reset=1, the block SHALL asynchronously force out_valid=0, rd1=rd2=0, out_tag=0, h1=h2=0 and stall_cnt=0; req_ready therefore reads 1.
REQ-026 Reset asserted mid-transfer SHALL discard the held entry; after reset deasserts, the first accepted request SHALL behave as from power-up.

Configuration
REQ-027 With macro REGREAD_BYPASS_EN defined, a request accepted while R_in[rsX]=1 (rsX!=0) SHALL capture G instead of rf_q[rsX] for that operand.
REQ-028 With REGREAD_BYPASS_EN defined, while out_valid && !out_ready, a cycle with R_in[hX]=1 (hX!=0) SHALL overwrite rdX with G.
REQ-029 Without REGREAD_BYPASS_EN, the block SHALL ignore G and R_in; the output is the pre-write rf_q value and held data is never refreshed.

Verification
REQ-030 Reset, then rf_q r5=32'hA5A5_0005, r9=32'h0000_0009; request rs1=5, rs2=9, tag=3 -> next cycle out_valid=1, rd1=32'hA5A5_0005, rd2=32'h9, out_tag=3.
REQ-031 Request rs1=0, rs2=0 with rf_q r0 field=32'hFFFF_FFFF -> rd1=rd2=0.
REQ-032 Hold out_ready=0 for 5 cycles with an entry valid -> req_ready=0, outputs stable, stall_cnt=5; then out_ready=1 with a new request in the same cycle -> new entry with no bubble.
REQ-033 REGREAD_BYPASS_EN defined: request rs1=7 with R_in=32'h80, G=32'hDEAD_BEEF, rf_q r7=1 -> rd1=32'hDEAD_BEEF; without the macro -> rd1=1.
REQ-034 REGREAD_BYPASS_EN defined: entry held with h2=12 and out_ready=0, then R_in=32'h1000, G=32'h1234 -> rd2=32'h1234 on the next cycle.
REQ-035 Assert reset while out_valid=1 and stall_cnt=3 -> out_valid=0, stall_cnt=0 immediately, without waiting for a clock edge.
